// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: CDB broadcast packet, ROB entry layout, and default depth.
package rob_pkg;
  localparam int XLEN       = 32;
  localparam int ROB_SZ_DEF = 8;
  // CDB tag is sized for the default depth; a deeper ROB needs this widened too
  localparam int CDB_TAG_W  = $clog2(ROB_SZ_DEF);
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] Tag;
    logic [XLEN-1:0]      Value;
    logic                 take_branch;
  } CDB_PACKET;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic            take_branch;
    logic [4:0]      dest_reg_idx;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] Value;
  } ROB_ENTRY;
endpackage

// File: rtl/rob.sv
// In-order-retire reorder buffer: dispatch at tail, CDB completion by tag, retire from head.
// Retire is combinational from registered state (CDB-to-retire takes 1 cycle); dp_ready drops only when full.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SZ = ROB_SZ_DEF,
  parameter int TAG_W  = $clog2(ROB_SZ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dp_valid,
  input  logic [4:0]       dp_dest_reg_idx,
  input  logic [XLEN-1:0]  dp_PC,
  output logic             dp_ready,
  output logic [TAG_W-1:0] dp_tag,
  input  CDB_PACKET        cdb_packet,
  output logic             rt_valid,
  output logic             rt_regfile_en,
  output logic [4:0]       rt_regfile_idx,
  output logic [XLEN-1:0]  rt_regfile_data,
  output logic [XLEN-1:0]  rt_PC,
  output logic             squash
);

  localparam logic [TAG_W:0] LP_FULL = (TAG_W+1)'(ROB_SZ);

  ROB_ENTRY         r_ent [ROB_SZ];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             w_rt_valid;
  logic             w_squash;
  logic             w_dp_fire;
  logic [TAG_W-1:0] w_cdb_tag;
  ROB_ENTRY         w_head_ent;

  assign w_head_ent = r_ent[r_head];
  assign w_rt_valid = w_head_ent.valid && w_head_ent.done;
  assign w_squash   = w_rt_valid && w_head_ent.take_branch;
  assign dp_ready   = (r_count != LP_FULL);
  assign dp_tag     = r_tail;
  assign w_dp_fire  = dp_valid && dp_ready;
  assign w_cdb_tag  = cdb_packet.Tag[TAG_W-1:0];

  always_comb begin
    rt_valid        = w_rt_valid;
    squash          = w_squash;
    rt_regfile_en   = 1'b0;
    rt_regfile_idx  = '0;
    rt_regfile_data = '0;
    rt_PC           = '0;
    if (w_rt_valid) begin
      rt_regfile_en   = (w_head_ent.dest_reg_idx != ZERO_REG);
      rt_regfile_idx  = w_head_ent.dest_reg_idx;
      rt_regfile_data = w_head_ent.Value;
      rt_PC           = w_head_ent.PC;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < ROB_SZ; i++) r_ent[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_squash) begin
      // Taken branch at retire: everything younger is wrong-path, including this cycle's dispatch/CDB
      for (int i = 0; i < ROB_SZ; i++) begin
        r_ent[i].valid <= 1'b0;
        r_ent[i].done  <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (cdb_packet.valid && r_ent[w_cdb_tag].valid) begin
        r_ent[w_cdb_tag].done        <= 1'b1;
        r_ent[w_cdb_tag].Value       <= cdb_packet.Value;
        r_ent[w_cdb_tag].take_branch <= cdb_packet.take_branch;
      end
      // Retire invalidation is ordered after the CDB write so a late CDB cannot revive the head
      if (w_rt_valid) begin
        r_ent[r_head].valid <= 1'b0;
        r_ent[r_head].done  <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      if (w_dp_fire) begin
        r_ent[r_tail] <= '{valid: 1'b1, done: 1'b0, take_branch: 1'b0,
                           dest_reg_idx: dp_dest_reg_idx, PC: dp_PC, Value: '0};
        r_tail        <= r_tail + 1'b1;
      end
      unique case ({w_dp_fire, w_rt_valid})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob.sv
// Randomized bench for rob: program-order queue model checked every cycle, plus directed literal scenarios.
module tb_rob;
  import rob_pkg::*;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            dp_valid = 1'b0;
  logic [4:0]      dp_dest_reg_idx = '0;
  logic [XLEN-1:0] dp_PC = '0;
  logic            dp_ready;
  logic [2:0]      dp_tag;
  CDB_PACKET       cdb_packet = '0;
  logic            rt_valid;
  logic            rt_regfile_en;
  logic [4:0]      rt_regfile_idx;
  logic [XLEN-1:0] rt_regfile_data;
  logic [XLEN-1:0] rt_PC;
  logic            squash;

  rob dut (
    .clock(clock), .reset(reset),
    .dp_valid(dp_valid), .dp_dest_reg_idx(dp_dest_reg_idx), .dp_PC(dp_PC),
    .dp_ready(dp_ready), .dp_tag(dp_tag), .cdb_packet(cdb_packet),
    .rt_valid(rt_valid), .rt_regfile_en(rt_regfile_en), .rt_regfile_idx(rt_regfile_idx),
    .rt_regfile_data(rt_regfile_data), .rt_PC(rt_PC), .squash(squash)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [31:0] pc;
    bit          done;
    logic [31:0] val;
    bit          br;
  } m_ent_t;

  m_ent_t q[$];
  int     m_tail = 0;
  int     total = 0;
  int     bad = 0;
  bit     chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_rt();
    return (q.size() > 0) && q[0].done;
  endfunction

  // Per-cycle comparison of every output against the in-order model
  always @(negedge clock) begin
    bit rt;
    if (chk_en) begin
      rt = m_rt();
      chk("dp_ready", dp_ready, q.size() < 8);
      chk("dp_tag", dp_tag, m_tail);
      chk("rt_valid", rt_valid, rt);
      chk("squash", squash, rt && q[0].br);
      chk("rt_en", rt_regfile_en, rt && (q[0].dest != 0));
      chk("rt_idx", rt_regfile_idx, rt ? q[0].dest : 5'd0);
      chk("rt_data", rt_regfile_data, rt ? q[0].val : 32'd0);
      chk("rt_PC", rt_PC, rt ? q[0].pc : 32'd0);
    end
  end

  task automatic cyc(input bit rst_n, input bit dv, input logic [4:0] dest, input logic [31:0] pc,
                     input bit cv, input int ctag, input logic [31:0] cval, input bit cbr);
    bit     rt, acc;
    m_ent_t e;
    reset = rst_n;
    dp_valid = dv;
    dp_dest_reg_idx = dest;
    dp_PC = pc;
    cdb_packet.valid = cv;
    cdb_packet.Tag = 3'(ctag);
    cdb_packet.Value = cval;
    cdb_packet.take_branch = cbr;
    @(posedge clock);
    rt  = m_rt();
    acc = dv && (q.size() < 8);
    if (!rst_n) begin
      q.delete();
      m_tail = 0;
    end else if (rt && q[0].br) begin
      q.delete();
      m_tail = 0;
    end else begin
      if (cv) foreach (q[i]) if (q[i].tag == ctag) begin
        q[i].done = 1;
        q[i].val  = cval;
        q[i].br   = cbr;
      end
      if (rt) void'(q.pop_front());
      if (acc) begin
        e.tag = m_tail; e.dest = dest; e.pc = pc; e.done = 0; e.val = 0; e.br = 0;
        q.push_back(e);
        m_tail = (m_tail + 1) % 8;
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ctag;
    do_reset();
    chk_en = 1;
    chk("reset dp_ready", dp_ready, 1);
    chk("reset dp_tag", dp_tag, 0);
    chk("reset rt_valid", rt_valid, 0);
    chk("reset squash", squash, 0);

    // Basic dispatch -> complete -> retire
    cyc(1, 1, 5, 32'h100, 0, 0, 0, 0);
    chk("s1 tag after dispatch", dp_tag, 1);
    chk("s1 no early retire", rt_valid, 0);
    cyc(1, 0, 0, 0, 1, 0, 32'h2A, 0);
    chk("s1 rt_valid", rt_valid, 1);
    chk("s1 rt_en", rt_regfile_en, 1);
    chk("s1 rt_idx", rt_regfile_idx, 5);
    chk("s1 rt_data", rt_regfile_data, 32'h2A);
    chk("s1 rt_PC", rt_PC, 32'h100);
    idle();
    chk("s1 drained", rt_valid, 0);

    // Fill, overflow attempt, wrap
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 1, 5'(i + 1), 32'h200 + 32'(4 * i), 0, 0, 0, 0);
    chk("s2 full", dp_ready, 0);
    cyc(1, 1, 5'd9, 32'h999, 0, 0, 0, 0);
    chk("s2 ninth ignored", dp_tag, 0);
    cyc(1, 0, 0, 0, 1, 0, 32'h7, 0);
    chk("s2 still full", dp_ready, 0);
    chk("s2 head ready", rt_PC, 32'h200);
    idle();
    chk("s2 ready after retire", dp_ready, 1);
    chk("s2 wrap tag", dp_tag, 0);

    // Out-of-order completion
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 5'(i + 10), 32'h300 + 32'(4 * i), 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 2, 32'h22, 0);
    cyc(1, 0, 0, 0, 1, 1, 32'h11, 0);
    chk("s3 blocked", rt_valid, 0);
    cyc(1, 0, 0, 0, 1, 0, 32'h00, 0);
    chk("s3 r0 PC", rt_PC, 32'h300);
    idle();
    chk("s3 r1 PC", rt_PC, 32'h304);
    chk("s3 r1 data", rt_regfile_data, 32'h11);
    idle();
    chk("s3 r2 PC", rt_PC, 32'h308);
    idle();
    chk("s3 empty", rt_valid, 0);

    // Destination x0
    do_reset();
    cyc(1, 1, 0, 32'h400, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 32'h55, 0);
    chk("s4 rt_valid", rt_valid, 1);
    chk("s4 no write", rt_regfile_en, 0);
    idle();

    // Mispredict squash
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 5'(i + 1), 32'h500 + 32'(4 * i), 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 32'hB1, 1);
    cyc(1, 0, 0, 0, 1, 2, 32'hB2, 0);
    cyc(1, 0, 0, 0, 1, 3, 32'hB3, 0);
    cyc(1, 0, 0, 0, 1, 0, 32'hB0, 0);
    chk("s5 r0 no squash", squash, 0);
    idle();
    chk("s5 squash", squash, 1);
    chk("s5 squash PC", rt_PC, 32'h504);
    cyc(1, 1, 5'd7, 32'h777, 1, 2, 32'hEE, 0);
    chk("s5 post tag", dp_tag, 0);
    chk("s5 post rt", rt_valid, 0);
    chk("s5 post ready", dp_ready, 1);
    cyc(1, 1, 5'd8, 32'h888, 0, 0, 0, 0);
    chk("s5 one entry", dp_tag, 1);
    idle();

    // Reset mid-flight with a concurrent CDB
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 5'(i + 1), 32'h600 + 32'(4 * i), 0, 0, 0, 0);
    cyc(0, 1, 5'd3, 32'h6FF, 1, 0, 32'hCC, 0);
    chk("s6 rt_valid", rt_valid, 0);
    chk("s6 dp_tag", dp_tag, 0);
    cyc(1, 0, 0, 0, 1, 0, 32'hCD, 0);
    chk("s6 stale cdb", rt_valid, 0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        cyc(0, $urandom_range(0, 1), 5'($urandom), $urandom, 1, $urandom_range(0, 7), $urandom, 0);
      end else begin
        if (q.size() > 0 && $urandom_range(0, 4) != 0) ctag = q[$urandom_range(0, q.size() - 1)].tag;
        else ctag = $urandom_range(0, 7);
        cyc(1, $urandom_range(0, 9) < 6, 5'($urandom), $urandom,
            $urandom_range(0, 9) < 7, ctag, $urandom, $urandom_range(0, 11) == 0);
      end
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
